// File: rtl/mtimer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : mtimer_pkg
// | Description : Shared constants and types for the machine-mode timer:
// |               register offsets, reset values, widths and the offset
// |               decoder used by the bus front end.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
package mtimer_pkg;

  localparam int MTIME_W = 64;

  localparam logic [MTIME_W-1:0] MTIMECMP_RST = '1;

  // Byte offsets from the register window base.
  localparam logic [31:0] MTIME_LO    = 32'h0000_0000;
  localparam logic [31:0] MTIME_HI    = 32'h0000_0004;
  localparam logic [31:0] MTIMECMP_LO = 32'h0000_0008;
  localparam logic [31:0] MTIMECMP_HI = 32'h0000_000C;
  localparam logic [31:0] MSIP        = 32'h0000_0010;

  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_MTIME_LO = 3'd1,
    SEL_MTIME_HI = 3'd2,
    SEL_CMP_LO   = 3'd3,
    SEL_CMP_HI   = 3'd4,
    SEL_MSIP     = 3'd5
  } reg_sel_e;

  // Maps a word-aligned offset to a register select. The msip slot only
  // decodes when the software-interrupt feature is built in; otherwise it
  // falls through to the unmapped case like any other offset.
  function automatic reg_sel_e decode(input logic [31:0] off, input logic msip_en);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (off == MTIME_LO)             sel = SEL_MTIME_LO;
    else if (off == MTIME_HI)        sel = SEL_MTIME_HI;
    else if (off == MTIMECMP_LO)     sel = SEL_CMP_LO;
    else if (off == MTIMECMP_HI)     sel = SEL_CMP_HI;
    else if (off == MSIP && msip_en) sel = SEL_MSIP;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtimer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : mtimer_if
// | Description : Register-access bus between the load/store path (master)
// |               and the timer (slave).
// | Signals     : req   - access request, at most one per cycle
// |               we    - 1 = write, 0 = read, valid with req
// |               addr  - byte address, bits [1:0] ignored
// |               wdata - write data
// |               rdata - read data, valid while ready = 1, else 0
// |               ready - one-cycle completion pulse per accepted req
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
interface mtimer_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, output we, output addr, output wdata,
                  input  rdata, input ready);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output rdata, output ready);
endinterface
`default_nettype wire

// File: rtl/mtimer_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : mtimer_prescaler
// | Description : Divides clk into a one-cycle tick every PRESCALE cycles.
// |               The count runs 0..PRESCALE-1 and the tick is high while
// |               the count sits at PRESCALE-1. With PRESCALE = 1 the tick
// |               is high every cycle.
// | Ports       : clk  - system clock
// |               rst  - synchronous active-high reset (count -> 0)
// |               tick - increment strobe for mtime
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
module mtimer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == c_LAST);
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mtimer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : mtimer
// | Description : Machine-mode timer. Holds the 64-bit free-running mtime
// |               counter and the 64-bit mtimecmp register behind a small
// |               memory-mapped window, and drives the registered timer
// |               interrupt level ti = (mtime >= mtimecmp).
// | Ports       : clk - system clock
// |               rst - synchronous active-high reset
// |               bus - register access port (mtimer_if.slave)
// |               ti  - timer interrupt level, registered
// |               si  - software interrupt level (only with MTIMER_MSIP_EN)
// | Options     : define MTIMER_MSIP_EN to add the msip register at offset
// |               0x10 and the si output.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
module mtimer
  import mtimer_pkg::*;
#(
  parameter int          PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic     clk,
  input  logic     rst,
  mtimer_if.slave  bus,
  output logic     ti
`ifdef MTIMER_MSIP_EN
  ,
  output logic     si
`endif
);

`ifdef MTIMER_MSIP_EN
  localparam logic c_MSIP_EN = 1'b1;
`else
  localparam logic c_MSIP_EN = 1'b0;
`endif

  logic [MTIME_W-1:0] r_mtime;
  logic [MTIME_W-1:0] r_mtimecmp;
  logic [31:0]        r_rdata;
  logic               r_ready;
  logic               r_ti;
`ifdef MTIMER_MSIP_EN
  logic               r_msip;
  logic               r_si;
`endif

  logic        w_tick;
  logic [31:0] w_off;
  reg_sel_e    w_sel;
  logic [31:0] w_rd_val;
  logic        w_wr;
  logic        w_unused_addr;

  mtimer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Byte-lane bits are ignored, so the offset is formed on word addresses.
  assign w_off         = {bus.addr[31:2] - BASE_ADDR[31:2], 2'b00};
  assign w_unused_addr = ^bus.addr[1:0];
  assign w_sel         = decode(w_off, c_MSIP_EN);
  assign w_wr          = bus.req & bus.we;

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_MTIME_LO: w_rd_val = r_mtime[31:0];
      SEL_MTIME_HI: w_rd_val = r_mtime[63:32];
      SEL_CMP_LO:   w_rd_val = r_mtimecmp[31:0];
      SEL_CMP_HI:   w_rd_val = r_mtimecmp[63:32];
`ifdef MTIMER_MSIP_EN
      SEL_MSIP:     w_rd_val = {31'd0, r_msip};
`endif
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= MTIMECMP_RST;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_ti       <= 1'b0;
`ifdef MTIMER_MSIP_EN
      r_msip     <= 1'b0;
      r_si       <= 1'b0;
`endif
    end else begin
      // Every request completes next cycle; read data reflects the
      // register contents before this cycle's update.
      r_ready <= bus.req;
      r_rdata <= (bus.req && !bus.we) ? w_rd_val : 32'd0;

      // Compare uses this cycle's register values, so ti lags by one.
      r_ti <= (r_mtime >= r_mtimecmp);

      // A write to either mtime half owns the whole counter for this
      // cycle; a coincident tick is dropped rather than deferred.
      if (w_wr && w_sel == SEL_MTIME_LO) begin
        r_mtime[31:0] <= bus.wdata;
      end else if (w_wr && w_sel == SEL_MTIME_HI) begin
        r_mtime[63:32] <= bus.wdata;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr && w_sel == SEL_CMP_LO) begin
        r_mtimecmp[31:0] <= bus.wdata;
      end
      if (w_wr && w_sel == SEL_CMP_HI) begin
        r_mtimecmp[63:32] <= bus.wdata;
      end

`ifdef MTIMER_MSIP_EN
      r_si <= r_msip;
      if (w_wr && w_sel == SEL_MSIP) begin
        r_msip <= bus.wdata[0];
      end
`endif
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign ti        = r_ti;
`ifdef MTIMER_MSIP_EN
  assign si        = r_si;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mtimer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : tb_mtimer
// | Description : Self-checking bench for mtimer. Two instances (PRESCALE 1
// |               and 4) share one stimulus stream; a behavioural model of
// |               each is advanced every clock and all outputs are compared
// |               every cycle, alongside hand-computed directed checks.
// |               Honours MTIMER_MSIP_EN.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_mtimer;

  localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef MTIMER_MSIP_EN
  localparam bit MSIP_EN = 1'b1;
`else
  localparam bit MSIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t_req = 1'b0;
  logic        t_we = 1'b0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;

  always #5 clk = ~clk;

  mtimer_if bus1 ();
  mtimer_if bus4 ();

  assign bus1.req = t_req;  assign bus1.we = t_we;
  assign bus1.addr = t_addr; assign bus1.wdata = t_wdata;
  assign bus4.req = t_req;  assign bus4.we = t_we;
  assign bus4.addr = t_addr; assign bus4.wdata = t_wdata;

  logic ti1, ti4;
  logic si1, si4;

  mtimer #(.PRESCALE(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1), .ti (ti1)
`ifdef MTIMER_MSIP_EN
    , .si (si1)
`endif
  );

  mtimer #(.PRESCALE(4), .BASE_ADDR(BASE)) u_dut4 (
    .clk (clk), .rst (rst), .bus (bus4), .ti (ti4)
`ifdef MTIMER_MSIP_EN
    , .si (si4)
`endif
  );

`ifndef MTIMER_MSIP_EN
  assign si1 = 1'b0;
  assign si4 = 1'b0;
`endif

  logic        d_ready [2];
  logic [31:0] d_rdata [2];
  logic        d_ti    [2];
  logic        d_si    [2];
  assign d_ready[0] = bus1.ready; assign d_ready[1] = bus4.ready;
  assign d_rdata[0] = bus1.rdata; assign d_rdata[1] = bus4.rdata;
  assign d_ti[0]    = ti1;        assign d_ti[1]    = ti4;
  assign d_si[0]    = si1;        assign d_si[1]    = si4;

  // ---------------- behavioural model ----------------
  int          ps   [2] = '{1, 4};
  longint unsigned m_time [2];
  longint unsigned m_cmp  [2];
  int          m_pc   [2];
  bit          m_rdy  [2];
  logic [31:0] m_rd   [2];
  bit          m_ti   [2];
  bit          m_msip [2];
  bit          m_si   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [31:0] word_off(input logic [31:0] a);
    return (a - BASE) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] mread(input int k, input logic [31:0] a);
    case (word_off(a))
      32'h0:  return m_time[k][31:0];
      32'h4:  return m_time[k][63:32];
      32'h8:  return m_cmp[k][31:0];
      32'hC:  return m_cmp[k][63:32];
      32'h10: return MSIP_EN ? {31'd0, m_msip[k]} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_time[k] = 0;
        m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_pc[k]   = 0;
        m_rdy[k]  = 0;
        m_rd[k]   = 0;
        m_ti[k]   = 0;
        m_msip[k] = 0;
        m_si[k]   = 0;
      end else begin
        bit tick;
        bit tw;
        tick = (m_pc[k] == ps[k] - 1);
        m_pc[k] = tick ? 0 : m_pc[k] + 1;
        m_ti[k]  = (m_time[k] >= m_cmp[k]);
        m_si[k]  = m_msip[k];
        m_rdy[k] = t_req;
        m_rd[k]  = (t_req && !t_we) ? mread(k, t_addr) : 32'd0;
        tw = 0;
        if (t_req && t_we) begin
          case (word_off(t_addr))
            32'h0: begin m_time[k][31:0]  = t_wdata; tw = 1; end
            32'h4: begin m_time[k][63:32] = t_wdata; tw = 1; end
            32'h8:  m_cmp[k][31:0]  = t_wdata;
            32'hC:  m_cmp[k][63:32] = t_wdata;
            32'h10: if (MSIP_EN) m_msip[k] = t_wdata[0];
            default: ;
          endcase
        end
        if (!tw && tick) m_time[k] = m_time[k] + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, then compare
  // every DUT output against the model on the following falling edge.
  task automatic step(input logic r, input logic q, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    rst = r; t_req = q; t_we = w; t_addr = a; t_wdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready[%0d]", k), 64'(d_ready[k]), 64'(m_rdy[k]));
      chk($sformatf("rdata[%0d]", k), 64'(d_rdata[k]), 64'(m_rd[k]));
      chk($sformatf("ti[%0d]", k),    64'(d_ti[k]),    64'(m_ti[k]));
      if (MSIP_EN) chk($sformatf("si[%0d]", k), 64'(d_si[k]), 64'(m_si[k]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, BASE, 32'd0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, BASE + off, d);
  endtask

  task automatic rd(input logic [31:0] off);
    step(1'b0, 1'b1, 1'b0, BASE + off, 32'd0);
  endtask

  logic [31:0] v1 [2];

  initial begin
    // Reset, including a request issued during reset that must be lost.
    step(1'b1, 1'b0, 1'b0, BASE, 32'd0);
    step(1'b1, 1'b1, 1'b0, BASE + 32'h8, 32'd0);
    step(1'b1, 1'b0, 1'b0, BASE, 32'd0);
    chk("reset ready", 64'(d_ready[0]), 64'd0);
    chk("reset ti",    64'(d_ti[0]),    64'd0);
    chk("reset rdata", 64'(d_rdata[0]), 64'd0);

    // Ten counting cycles after reset.
    idle(10);
    rd(32'h0);
    chk("mtime after 10 (P1)", 64'(d_rdata[0]), 64'd10);
    chk("mtime after 10 (P4)", 64'(d_rdata[1]), 64'd2);

    // Low-to-high carry.
    wr(32'h0, 32'hFFFF_FFFF);
    wr(32'h4, 32'h0);
    idle(1);
    rd(32'h0);
    chk("carry lo", 64'(d_rdata[0]), 64'd0);
    rd(32'h4);
    chk("carry hi", 64'(d_rdata[0]), 64'd1);

    // Full 64-bit wrap.
    wr(32'h0, 32'hFFFF_FFFF);
    wr(32'h4, 32'hFFFF_FFFF);
    idle(1);
    rd(32'h0);
    chk("wrap lo", 64'(d_rdata[0]), 64'd0);
    rd(32'h4);
    chk("wrap hi", 64'(d_rdata[0]), 64'd0);

    // Interrupt rise exactly one cycle after mtime reaches mtimecmp.
    wr(32'hC, 32'd0);
    wr(32'h8, 32'd100);
    wr(32'h4, 32'd0);
    wr(32'h0, 32'd95);
    idle(5);
    chk("ti before cmp", 64'(d_ti[0]), 64'd0);
    idle(1);
    chk("ti at cmp+1", 64'(d_ti[0]), 64'd1);
    wr(32'hC, 32'd1);
    chk("ti holds on cmp write", 64'(d_ti[0]), 64'd1);
    idle(1);
    chk("ti clears after cmp raise", 64'(d_ti[0]), 64'd0);

    // Write colliding with a tick: written value wins, no increment.
    wr(32'h0, 32'd5);
    rd(32'h0);
    chk("collision lo", 64'(d_rdata[0]), 64'd5);
    rd(32'h4);
    chk("collision hi", 64'(d_rdata[0]), 64'd0);

    // Forty-cycle span: P1 advances 40, P4 exactly 10, regardless of phase,
    // with an mtime write in the middle of an otherwise idle stretch.
    rd(32'h0);
    v1[0] = d_rdata[0]; v1[1] = d_rdata[1];
    idle(39);
    rd(32'h0);
    chk("span P1", 64'(d_rdata[0] - v1[0]), 64'd40);
    chk("span P4", 64'(d_rdata[1] - v1[1]), 64'd10);
    idle(2);
    wr(32'h0, 32'd7);
    idle(9);

    // Back-to-back bus traffic after a fresh reset.
    step(1'b1, 1'b0, 1'b0, BASE, 32'd0);
    rd(32'h8);
    chk("b2b cmp lo ready", 64'(d_ready[0]), 64'd1);
    chk("b2b cmp lo",       64'(d_rdata[0]), 64'hFFFF_FFFF);
    rd(32'h14);
    chk("b2b unmapped ready", 64'(d_ready[0]), 64'd1);
    chk("b2b unmapped",       64'(d_rdata[0]), 64'd0);
    wr(32'h20, 32'hDEAD_BEEF);
    chk("b2b write ready", 64'(d_ready[0]), 64'd1);
    chk("b2b write rdata", 64'(d_rdata[0]), 64'd0);
    idle(1);
    chk("b2b ready drops", 64'(d_ready[0]), 64'd0);

    // msip slot.
    wr(32'h10, 32'd1);
    idle(1);
    rd(32'h10);
    chk("msip read", 64'(d_rdata[0]), MSIP_EN ? 64'd1 : 64'd0);
    chk("si level",  64'(d_si[0]),    MSIP_EN ? 64'd1 : 64'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic        r, q, w;
      logic [31:0] a, d;
      int          pick;
      r = ($urandom_range(0, 99) == 0);
      q = ($urandom_range(0, 2) != 0);
      w = $urandom_range(0, 1);
      pick = $urandom_range(0, 7);
      if (pick <= 5)      a = BASE + 32'(4 * pick) + 32'($urandom_range(0, 3));
      else if (pick == 6) a = BASE + 32'(4 * $urandom_range(6, 1023));
      else                a = $urandom;
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
      step(r, q, w, a, d);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
